mux_n_1_reg: RTL
================

# mux_n_1_reg

Parametrised, registered N:1 multiplexer with a manual-select mode and an auto-scan mode. It is the clocked successor to the fixed 8:1 combinational mux. Width and channel count are generic, and the output is registered with a valid flag. A built-in sequencer can walk all channels in order and flag each wrap. It sits between multi-channel data sources and a single downstream consumer, and is used both as a benchmark design and as a channel-scan front end.

## Interface
Parameters:
- NCH, 8, number of input channels (2..64; need not be a power of two)
- W, 1, data width per channel in bits
- SW, $clog2(NCH), select / index width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- D  input  NCH*W  flattened channel data; channel i is D[i*W +: W]
- sel  input  SW  requested channel index
- sel_load  input  1  load sel on this enabled edge
- mode  input  1  0 = manual, 1 = auto-scan
- en  input  1  clock enable for the whole datapath
- out  output  W  registered selected data
- out_valid  output  1  out was updated on the last edge
- ch_idx  output  SW  channel index that produced out
- wrap  output  1  one-cycle pulse: scan stepped from NCH-1 to 0
- err  output  1  one-cycle pulse: sel_load with sel >= NCH

## Operation
- Internal registers:
  - cur_idx (SW bits)
  - state, one of S_MAN or S_SCAN
- Reset (async, rst=1): cur_idx=0, state=S_MAN, out=0, out_valid=0, ch_idx=0, wrap=0, err=0. All are held while rst=1.
- en=0 edge:
  - cur_idx, state, out and ch_idx hold.
  - out_valid, wrap and err are forced to 0.
- en=1 edge: compute next_idx, then cur_idx<=next_idx, ch_idx<=next_idx, out<=D[next_idx], out_valid<=1.
- sel_load with sel < NCH takes priority in both modes: next_idx=sel, wrap=0.
- Manual mode (mode=0):
  - sel_load with sel >= NCH: next_idx=cur_idx, err<=1.
  - No sel_load: next_idx=cur_idx.
  - state<=S_MAN.
- Auto-scan (mode=1):
  - state S_MAN (first enabled scan edge after reset or mode entry): next_idx=cur_idx (current channel is presented first), then state<=S_SCAN.
  - state S_SCAN: next_idx = (cur_idx==NCH-1) ? 0 : cur_idx+1. wrap<=1 only on the NCH-1 to 0 step.
  - A valid sel_load in S_SCAN jumps to sel. Scanning continues from sel on the next edge.
  - An invalid sel_load in S_SCAN gives err<=1 and advances normally.
- Switching mode from 1 to 0 on an enabled edge: state<=S_MAN and next_idx follows the manual rules.
- Index arithmetic is SW-bit unsigned. It never exceeds NCH-1 because the wrap is explicit, not modulo 2^SW.

## Timing
- Latency: D, sel and mode sampled at edge k appear on out, ch_idx and out_valid after edge k. There is one cycle of latency and no combinational input-to-output path.
- Scan period: NCH enabled edges per full sweep. wrap occurs once per sweep, coincident with out=D[0].
- en stalls freeze the scan position. Resuming continues from the next channel, and no channel is skipped or repeated.
- Reset asserted mid-scan clears everything asynchronously. The first enabled scan edge after release presents channel 0.
- sel_load and wrap on the same edge: sel_load wins and wrap stays 0.
- sel_load with en=0 is ignored and err stays 0.

## Test plan
- Manual sweep, NCH=8, W=1, D=8'b01010101 (channel 0 =1): sel_load each index 0..7 on consecutive edges. Each following cycle out must equal D[sel] (1,0,1,0,...) with ch_idx=sel and out_valid=1. Compare against a behavioural golden mux and count mismatches (must be 0).
- Auto-scan, NCH=5, W=4, D[i]=i+3: mode=1, en=1 for 12 edges. ch_idx must be 0,1,2,3,4,0,1,... with out=ch_idx+3 and wrap high only on the edges where ch_idx returns to 0.
- Invalid select, NCH=5: sel=6 with sel_load in manual. err must pulse for exactly 1 cycle and ch_idx must be unchanged. The same in scan mode must also advance normally.
- Stall: scan NCH=8, drop en for 3 cycles at ch_idx=3. out_valid must be 0 and out/ch_idx held. After en returns, ch_idx must be 4.
- Async reset mid-scan: assert rst between edges at ch_idx=5. All outputs must go to 0 immediately, without waiting for an edge. After release the first scan edge must give ch_idx=0, then 1.
- Jump priority: scan at ch_idx=7 (NCH=8), sel_load sel=2 on the wrap edge. The edge must give ch_idx=2 with wrap=0, and the next edge ch_idx=3.

Source files
------------

// File: rtl/mux_n_1_reg.sv
// Registered N:1 multiplexer with manual-select and auto-scan modes.
// One cycle of latency from D/sel/mode to out/ch_idx/out_valid.
// The scan sequencer walks channels 0..NCH-1 and pulses wrap on each return to 0.
module mux_n_1_reg #(
    parameter int NCH = 8,
    parameter int W   = 1,
    parameter int SW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*W-1:0]  D,
    input  logic [SW-1:0]     sel,
    input  logic              sel_load,
    input  logic              mode,
    input  logic              en,
    output logic [W-1:0]      out,
    output logic              out_valid,
    output logic [SW-1:0]     ch_idx,
    output logic              wrap,
    output logic              err
);

    typedef enum logic {
        S_MAN  = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    // One extra bit so that NCH itself is representable when NCH is a power of two.
    localparam logic [SW:0]   NCH_EXT  = (SW+1)'(NCH);
    localparam logic [SW-1:0] LAST_IDX = SW'(NCH - 1);

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] cur_idx;
    logic [SW-1:0] next_idx;
    logic          next_wrap;
    logic          next_err;
    logic          sel_ok;
    logic          sel_bad;

    // Unpacked view of the flattened channel bus.
    logic [W-1:0]  ch_data [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign ch_data[i] = D[i*W +: W];
    end

    assign sel_ok  = sel_load && ({1'b0, sel} < NCH_EXT);
    assign sel_bad = sel_load && !sel_ok;

    // Next channel index, next state and the wrap/err pulses for the coming enabled edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a
        // value unassigned and no latch is inferred.
        next_idx   = cur_idx;
        next_state = S_MAN;
        next_wrap  = 1'b0;
        next_err   = sel_bad;

        if (mode) begin
            next_state = S_SCAN;
            if (state == S_SCAN) begin
                if (cur_idx == LAST_IDX) begin
                    // Explicit wrap: the index never runs past NCH-1 even when NCH < 2**SW.
                    next_idx  = '0;
                    next_wrap = 1'b1;
                end else begin
                    next_idx = cur_idx + 1'b1;
                end
            end
            // In S_MAN the current channel is presented first, so next_idx stays cur_idx.
        end

        // A valid load overrides both modes and suppresses any wrap on this edge.
        if (sel_ok) begin
            next_idx  = sel;
            next_wrap = 1'b0;
        end
    end

    // State, index and registered outputs; a disabled edge freezes the datapath and
    // clears the single-cycle flags.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state     <= S_MAN;
            cur_idx   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            ch_idx    <= '0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else if (en) begin
            state     <= next_state;
            cur_idx   <= next_idx;
            ch_idx    <= next_idx;
            out       <= ch_data[next_idx];
            out_valid <= 1'b1;
            wrap      <= next_wrap;
            err       <= next_err;
        end else begin
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end
    end

endmodule
